// File: rtl/psk_pkg.sv
// psk_pkg: shared constants, splitter state type and phase-rotation helpers for the PSK path
// Contents:
//   SAMPLE_W          carrier pattern width, reused by the modulator
//   BASE_PATTERN_DEF  default phase-0 carrier pattern
//   split_state_t     splitter FSM states
//   rot_step(bps)     rotation bits per symbol step
//   psk_pattern(...)  base pattern rotated right by sym*rot_step(bps), modulo 8
package psk_pkg;

    localparam int SAMPLE_W = 8;
    localparam logic [SAMPLE_W-1:0] BASE_PATTERN_DEF = 8'h0F;

    typedef enum logic {IDLE, BUSY} split_state_t;

    function automatic int rot_step(input int bps);
        return 8 >> bps;
    endfunction

    function automatic logic [SAMPLE_W-1:0] psk_pattern(
        input logic [SAMPLE_W-1:0] base,
        input logic [2:0]          sym,
        input int                  bps
    );
        logic [2:0] amt;
        // The 3-bit cast wraps the rotation amount modulo 8.
        amt = 3'(int'(sym) * rot_step(bps));
        // Rotating right by amt is the low half of the doubled pattern shifted by amt.
        return SAMPLE_W'({base, base} >> amt);
    endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// sync_fifo_fwft: first-word-fall-through FIFO with level count and sticky underflow flag
// Ports:
//   clk, rst          clock, asynchronous active-low reset
//   wr, wdata, full   write request (ignored when full), write data, full flag
//   rd, rdata, empty  pop request (ignored when empty), head data (0 when empty), empty flag
//   level             current entry count
//   underflow         set by rd while empty, held until reset
module sync_fifo_fwft #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr,
    input  logic [WIDTH-1:0]         wdata,
    output logic                     full,
    input  logic                     rd,
    output logic [WIDTH-1:0]         rdata,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     underflow
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic             do_wr, do_rd;

    assign full  = level == (AW+1)'(DEPTH);
    assign empty = level == '0;
    // Fullness is judged before any same-cycle pop, so a pop at full never frees room that cycle.
    assign do_wr = wr && !full;
    assign do_rd = rd && !empty;
    assign rdata = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr] <= wdata;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= '0;
            underflow <= 1'b0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
            level <= level + (AW+1)'(do_wr) - (AW+1)'(do_rd);
            if (rd && empty) underflow <= 1'b1;
        end
    end

endmodule

// File: rtl/psk_symbol_mapper.sv
// psk_symbol_mapper: splits host bytes LSB-first into PSK symbols and queues their rotated carrier patterns
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   data_in, data_valid      host byte and its valid
//   data_ready               high when no byte is being split
//   sample, empty, read      FIFO head pattern, empty flag, pop request (modulator side)
//   full, level, underflow   FIFO full flag, entry count, sticky read-while-empty flag
module psk_symbol_mapper
    import psk_pkg::*;
#(
    parameter int                  BITS_PER_SYMBOL = 1,
    parameter logic [SAMPLE_W-1:0] BASE_PATTERN    = BASE_PATTERN_DEF,
    parameter int                  FIFO_DEPTH      = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [7:0]                   data_in,
    input  logic                         data_valid,
    output logic                         data_ready,
    output logic [SAMPLE_W-1:0]          sample,
    output logic                         empty,
    input  logic                         read,
    output logic                         full,
    output logic [$clog2(FIFO_DEPTH):0]  level,
    output logic                         underflow
);

    // 8-PSK gets a third, 2-bit symbol from bits [7:6], so round the symbol count up.
    localparam int         N_SYM    = (8 + BITS_PER_SYMBOL - 1) / BITS_PER_SYMBOL;
    localparam logic [2:0] LAST_IDX = 3'(N_SYM - 1);
    localparam logic [2:0] SYM_MASK = 3'((1 << BITS_PER_SYMBOL) - 1);

    split_state_t        state, state_nx;
    logic [7:0]          hold;
    logic [2:0]          idx;
    logic [2:0]          sym;
    logic                accept, wr;
    logic [SAMPLE_W-1:0] pattern;

    assign data_ready = state == IDLE;

    always_comb begin
        accept   = data_valid && state == IDLE;
        wr       = state == BUSY && !full;
        // Bits shifted in above bit 7 are zero, which zero-extends the short last 8-PSK symbol.
        sym      = 3'(hold >> (int'(idx) * BITS_PER_SYMBOL)) & SYM_MASK;
        pattern  = psk_pattern(BASE_PATTERN, sym, BITS_PER_SYMBOL);
        state_nx = accept ? BUSY : (wr && idx == LAST_IDX) ? IDLE : state;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            hold  <= '0;
            idx   <= '0;
        end else begin
            state <= state_nx;
            if (accept) begin
                hold <= data_in;
                idx  <= '0;
            end else if (wr) begin
                idx <= idx + 3'd1;
            end
        end
    end

    sync_fifo_fwft #(
        .WIDTH(SAMPLE_W),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .wr       (wr),
        .wdata    (pattern),
        .full     (full),
        .rd       (read),
        .rdata    (sample),
        .empty    (empty),
        .level    (level),
        .underflow(underflow)
    );

endmodule
